// File: rtl/img_proc_pkg.sv
// Shared types and defaults for the N-slave pixel-processing arbiter.
// Used by the RTL and by the testbench.
package img_proc_pkg;

  localparam int DEF_COLOR_SIZE = 8;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_SUB  = 2'b10,
    MODE_INV  = 2'b11
  } mode_e;

  // Arbiter FSM encoding, kept as plain constants so older tooling can decode it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BURST = 2'd1;
  localparam state_t ST_CMPLT = 2'd2;

endpackage

// File: rtl/pixel_alu.sv
// Per-component colour operation applied to one beat: pass, saturating add,
// saturating subtract or invert.
module pixel_alu
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COLOR_SIZE = DEF_COLOR_SIZE
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  mode_e                 mode,
  input  logic [COLOR_SIZE-1:0] proc_val,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int NUM_COMP = DATA_WIDTH / COLOR_SIZE;

  genvar i;
  generate
    for (i = 0; i < NUM_COMP; i++) begin : g_comp
      logic [COLOR_SIZE-1:0] c;
      logic [COLOR_SIZE:0]   sum;
      logic [COLOR_SIZE-1:0] res;

      assign c   = data[i*COLOR_SIZE +: COLOR_SIZE];
      // One extra bit so the carry out of the add flags saturation.
      assign sum = {1'b0, c} + {1'b0, proc_val};

      always_comb begin
        res = c;
        unique case (mode)
          MODE_PASS: res = c;
          MODE_ADD:  res = sum[COLOR_SIZE] ? '1 : sum[COLOR_SIZE-1:0];
          MODE_SUB:  res = (c >= proc_val) ? (c - proc_val) : '0;
          MODE_INV:  res = ~c;
          default:   res = c;
        endcase
      end

      assign result[i*COLOR_SIZE +: COLOR_SIZE] = res;
    end
  endgenerate

endmodule

// File: rtl/img_proc_arb_n.sv
// Round-robin burst arbiter over NUM_SLV slave channels feeding one registered
// master port; each granted burst gets its own latched colour operation.
module img_proc_arb_n
  import img_proc_pkg::*;
#(
  parameter int NUM_SLV    = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COLOR_SIZE = DEF_COLOR_SIZE,
  parameter int BURST_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2*NUM_SLV-1:0]          slv_mode,
  input  logic [NUM_SLV-1:0]            slv_data_valid,
  input  logic [COLOR_SIZE*NUM_SLV-1:0] slv_proc_val,
  input  logic [DATA_WIDTH*NUM_SLV-1:0] slv_data,
  output logic [NUM_SLV-1:0]            slv_rdy,
  input  logic                          mstr_ready,
  output logic [DATA_WIDTH-1:0]         mstr_data,
  output logic [NUM_SLV-1:0]            mstr_data_valid,
  output logic                          mstr_cmplt
);

  // Handshakes: a beat moves on a cycle where valid and ready are both high;
  // a source may drop valid at any time, which ends its burst.
  localparam int GW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [GW-1:0] LAST_SLV  = GW'(NUM_SLV - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  state_t                  state;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           pick;
  int                      scan_idx;
  logic [CW-1:0]           beat_cnt;
  mode_e                   mode_q;
  logic [COLOR_SIZE-1:0]   proc_q;
  logic                    out_valid;
  logic [GW-1:0]           out_src;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    cmplt_q;
  logic                    rdy_ok;
  logic                    slv_fire;
  logic                    mstr_fire;

  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    pick     = '0;
    scan_idx = 0;
    for (int k = NUM_SLV; k >= 1; k--) begin
      scan_idx = (int'(last_grant) + k) % NUM_SLV;
      if (slv_data_valid[scan_idx]) pick = GW'(scan_idx);
    end
  end

  assign rdy_ok    = !out_valid || mstr_ready;
  assign slv_fire  = (state == ST_BURST) && slv_data_valid[grant] && rdy_ok;
  assign mstr_fire = out_valid && mstr_ready;
  assign sel_data  = slv_data[grant*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    slv_rdy = '0;
    if (state == ST_BURST) slv_rdy[grant] = rdy_ok;
  end

  pixel_alu #(
    .DATA_WIDTH(DATA_WIDTH),
    .COLOR_SIZE(COLOR_SIZE)
  ) u_alu (
    .data    (sel_data),
    .mode    (mode_q),
    .proc_val(proc_q),
    .result  (alu_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= LAST_SLV;
      beat_cnt   <= '0;
      mode_q     <= MODE_PASS;
      proc_q     <= '0;
      out_valid  <= 1'b0;
      out_src    <= '0;
      out_data   <= '0;
      cmplt_q    <= 1'b0;
    end else begin
      cmplt_q <= 1'b0;
      if (mstr_fire) out_valid <= 1'b0;
      if (slv_fire) begin
        out_valid <= 1'b1;
        out_data  <= alu_result;
        out_src   <= grant;
      end

      case (state)
        ST_IDLE: begin
          if (|slv_data_valid) begin
            grant    <= pick;
            mode_q   <= mode_e'(slv_mode[2*pick +: 2]);
            proc_q   <= slv_proc_val[pick*COLOR_SIZE +: COLOR_SIZE];
            beat_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (!slv_data_valid[grant]) begin
            state <= ST_CMPLT;
          end else if (slv_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) state <= ST_CMPLT;
          end
        end
        ST_CMPLT: begin
          // Completion waits until the last beat has left the output register.
          if (rdy_ok) begin
            cmplt_q    <= (beat_cnt != '0);
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mstr_data_valid = '0;
    if (out_valid) mstr_data_valid[out_src] = 1'b1;
  end

  assign mstr_data  = out_data;
  assign mstr_cmplt = cmplt_q;

endmodule

// File: tb/tb_img_proc_arb_n.sv
// Self-checking bench for img_proc_arb_n: directed scenarios plus random traffic,
// all checked against a transaction-level arbitration and colour model.
module tb_img_proc_arb_n;
  import img_proc_pkg::*;

  localparam int NS = 4;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int CS = DEF_COLOR_SIZE;
  localparam int BL = 4;
  localparam int NC = DW / CS;
  localparam int EV_CMPLT = 100;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [2*NS-1:0]    slv_mode;
  logic [NS-1:0]      slv_data_valid;
  logic [CS*NS-1:0]   slv_proc_val;
  logic [DW*NS-1:0]   slv_data;
  logic [NS-1:0]      slv_rdy;
  logic               mstr_ready;
  logic [DW-1:0]      mstr_data;
  logic [NS-1:0]      mstr_data_valid;
  logic               mstr_cmplt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  img_proc_arb_n #(
    .NUM_SLV   (NS),
    .DATA_WIDTH(DW),
    .COLOR_SIZE(CS),
    .BURST_LEN (BL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .slv_mode       (slv_mode),
    .slv_data_valid (slv_data_valid),
    .slv_proc_val   (slv_proc_val),
    .slv_data       (slv_data),
    .slv_rdy        (slv_rdy),
    .mstr_ready     (mstr_ready),
    .mstr_data      (mstr_data),
    .mstr_data_valid(mstr_data_valid),
    .mstr_cmplt     (mstr_cmplt)
  );

  // ---------------- reference model ----------------
  logic [NS+DW-1:0] exp_q[$];
  int               ev_log[$];
  int               blen_log[$];
  bit               mon_en = 1'b0;
  bit               in_burst = 1'b0;
  int               m_last = NS - 1;
  int               m_g = 0;
  int               m_beats = 0;
  int               pending = 0;
  int               idle_cnt = 1;
  logic [1:0]       m_mode;
  logic [CS-1:0]    m_proc;
  logic [NS-1:0]    prev_valid;
  logic [2*NS-1:0]  prev_mode;
  logic [CS*NS-1:0] prev_proc;

  function automatic logic [DW-1:0] ref_op(input logic [1:0] mode, input logic [CS-1:0] p,
                                           input logic [DW-1:0] d);
    int x;
    int mx;
    logic [DW-1:0] r;
    mx = (1 << CS) - 1;
    r  = '0;
    for (int c = 0; c < NC; c++) begin
      x = int'(d[c*CS +: CS]);
      case (mode)
        2'b00: x = x;
        2'b01: x = (x + int'(p) > mx) ? mx : x + int'(p);
        2'b10: x = (x > int'(p)) ? x - int'(p) : 0;
        default: x = mx - x;
      endcase
      r[c*CS +: CS] = x[CS-1:0];
    end
    return r;
  endfunction

  function automatic int rr_pick(input int last, input logic [NS-1:0] v);
    int idx;
    for (int k = 1; k <= NS; k++) begin
      idx = (last + k) % NS;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    int occ;
    int exp_g;
    logic [NS-1:0] exp_rdy;
    logic [NS-1:0] tag;
    logic [NS+DW-1:0] want;
    if (!rst_n) begin
      in_burst = 1'b0;
      m_last   = NS - 1;
      pending  = 0;
      idle_cnt = 1;
      exp_q.delete();
    end else if (mon_en) begin
      occ = exp_q.size();
      checks++;
      if ((mstr_data_valid != '0) !== (occ != 0)) begin
        failures++;
        $display("FAIL mon_out_valid: mstr_data_valid=%b model_occupancy=%0d", mstr_data_valid, occ);
      end
      if (mstr_data_valid != '0 && mstr_ready && occ != 0) begin
        want = exp_q.pop_front();
        checks++;
        if ({mstr_data_valid, mstr_data} !== want) begin
          failures++;
          $display("FAIL mon_beat: got tag=%b data=%h want tag=%b data=%h",
                   mstr_data_valid, mstr_data, want[NS+DW-1:DW], want[DW-1:0]);
        end
      end
      if (mstr_cmplt) begin
        checks++;
        if (pending == 0 || occ != 0 || mstr_data_valid != '0) begin
          failures++;
          $display("FAIL mon_cmplt: pending=%0d occupancy=%0d tag=%b", pending, occ, mstr_data_valid);
        end else pending--;
        ev_log.push_back(EV_CMPLT);
      end
      checks++;
      if ($countones(slv_rdy) > 1) begin
        failures++;
        $display("FAIL mon_rdy_onehot: slv_rdy=%b", slv_rdy);
      end
      if (!in_burst) begin
        if (slv_rdy != '0) begin
          exp_g = rr_pick(m_last, prev_valid);
          exp_rdy = '0;
          if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
          checks++;
          if (idle_cnt < 2 || slv_rdy !== exp_rdy) begin
            failures++;
            $display("FAIL mon_grant: slv_rdy=%b want=%b idle_cycles=%0d", slv_rdy, exp_rdy, idle_cnt);
          end
          m_g      = (exp_g >= 0) ? exp_g : 0;
          in_burst = 1'b1;
          m_beats  = 0;
          m_mode   = prev_mode[2*m_g +: 2];
          m_proc   = prev_proc[m_g*CS +: CS];
          ev_log.push_back(m_g);
        end else idle_cnt++;
      end
      if (in_burst) begin
        exp_rdy = '0;
        if (occ == 0 || mstr_ready) exp_rdy[m_g] = 1'b1;
        checks++;
        if (slv_rdy !== exp_rdy) begin
          failures++;
          $display("FAIL mon_slv_rdy: slv_rdy=%b want=%b", slv_rdy, exp_rdy);
        end
        if (slv_data_valid[m_g] && slv_rdy[m_g]) begin
          tag = '0;
          tag[m_g] = 1'b1;
          exp_q.push_back({tag, ref_op(m_mode, m_proc, slv_data[m_g*DW +: DW])});
          m_beats++;
        end
        if (m_beats == BL || !slv_data_valid[m_g]) begin
          in_burst = 1'b0;
          m_last   = m_g;
          idle_cnt = 0;
          if (m_beats > 0) pending++;
          blen_log.push_back(m_beats);
        end
      end
    end
    prev_valid = slv_data_valid;
    prev_mode  = slv_mode;
    prev_proc  = slv_proc_val;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slave(input int i, input logic v, input logic [1:0] m,
                           input logic [CS-1:0] p, input logic [DW-1:0] d);
    slv_data_valid[i]    = v;
    slv_mode[2*i +: 2]   = m;
    slv_proc_val[i*CS +: CS] = p;
    slv_data[i*DW +: DW] = d;
  endtask

  task automatic drain(input int n);
    slv_data_valid = '0;
    mstr_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    slv_data_valid = '0;
    step();
    rst_n = 1'b1;
    ev_log.delete();
    blen_log.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    @(negedge clk);
    checks++; if (slv_rdy !== '0) begin failures++; $display("FAIL reset_slv_rdy: got=%b want=0", slv_rdy); end
    checks++; if (mstr_data !== '0) begin failures++; $display("FAIL reset_mstr_data: got=%h want=0", mstr_data); end
    checks++; if (mstr_data_valid !== '0) begin failures++; $display("FAIL reset_mstr_valid: got=%b want=0", mstr_data_valid); end
    checks++; if (mstr_cmplt !== 1'b0) begin failures++; $display("FAIL reset_cmplt: got=%b want=0", mstr_cmplt); end
    mon_en = 1'b1;
    step();
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checks++;
      if (slv_rdy !== '0) begin failures++; $display("FAIL idle_no_rdy: got=%b want=0", slv_rdy); end
    end
    step();
  endtask

  task automatic test_single_add();
    int acc = 0, outs = 0, cmp = 0, a_cyc = -1, o_cyc = -1;
    mstr_ready = 1'b1;
    set_slave(0, 1'b1, 2'b01, 8'h20, 32'hF0_10_E5_00);
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (slv_data_valid[0] && slv_rdy[0]) begin acc++; if (a_cyc < 0) a_cyc = t; end
      if (mstr_data_valid != '0) begin
        if (o_cyc < 0) o_cyc = t;
        outs++;
        checks++;
        if (mstr_data !== 32'hFF_30_FF_20 || mstr_data_valid !== 4'b0001) begin
          failures++;
          $display("FAIL single_beat: got tag=%b data=%h want tag=0001 data=ff30ff20", mstr_data_valid, mstr_data);
        end
      end
      if (mstr_cmplt) cmp++;
      step();
      if (acc == 3) slv_data_valid[0] = 1'b0;
    end
    checks++; if (acc != 3) begin failures++; $display("FAIL single_accepts: got=%0d want=3", acc); end
    checks++; if (outs != 3) begin failures++; $display("FAIL single_outs: got=%0d want=3", outs); end
    checks++; if (o_cyc != a_cyc + 1) begin failures++; $display("FAIL single_latency: got=%0d want=1", o_cyc - a_cyc); end
    checks++; if (cmp != 1) begin failures++; $display("FAIL single_cmplt_count: got=%0d want=1", cmp); end
  endtask

  task automatic test_round_robin();
    int exp_ev[9] = '{0, EV_CMPLT, 1, EV_CMPLT, 2, EV_CMPLT, 3, EV_CMPLT, 0};
    int n = 0;
    do_reset();
    mstr_ready = 1'b1;
    while (ev_log.size() < 9 && n < 300) begin
      for (int i = 0; i < NS; i++)
        set_slave(i, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), $urandom);
      step();
      n++;
    end
    drain(12);
    checks++;
    if (ev_log.size() < 9) begin
      failures++;
      $display("FAIL rr_timeout: events=%0d want>=9", ev_log.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (ev_log[k] != exp_ev[k]) begin
          failures++;
          $display("FAIL rr_event_%0d: got=%0d want=%0d", k, ev_log[k], exp_ev[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (blen_log[k] != BL) begin
          failures++;
          $display("FAIL rr_burst_len_%0d: got=%0d want=%0d", k, blen_log[k], BL);
        end
      end
    end
  endtask

  task automatic test_stall();
    int pat[4] = '{1, 0, 0, 1};
    int acc = 0, outs = 0;
    bit have_prev = 1'b0;
    logic [NS-1:0] prev_tag;
    logic [DW-1:0] prev_dat;
    mstr_ready = 1'b1;
    set_slave(2, 1'b1, 2'b10, 8'h30, 32'h20_40_00_FF);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (have_prev) begin
        checks++;
        if (mstr_data_valid !== prev_tag || mstr_data !== prev_dat) begin
          failures++;
          $display("FAIL stall_hold: got tag=%b data=%h want tag=%b data=%h", mstr_data_valid, mstr_data, prev_tag, prev_dat);
        end
      end
      have_prev = (mstr_data_valid != '0) && !mstr_ready;
      prev_tag  = mstr_data_valid;
      prev_dat  = mstr_data;
      if (slv_data_valid[2] && slv_rdy[2]) acc++;
      if (mstr_data_valid != '0 && mstr_ready) begin
        outs++;
        checks++;
        if (mstr_data !== 32'h00_10_00_CF || mstr_data_valid !== 4'b0100) begin
          failures++;
          $display("FAIL stall_beat: got tag=%b data=%h want tag=0100 data=001000cf", mstr_data_valid, mstr_data);
        end
      end
      step();
      mstr_ready = pat[t % 4][0];
      if (acc == 4) slv_data_valid[2] = 1'b0;
    end
    drain(6);
    checks++; if (outs != 4) begin failures++; $display("FAIL stall_out_count: got=%0d want=4", outs); end
    checks++; if (acc != 4) begin failures++; $display("FAIL stall_accepts: got=%0d want=4", acc); end
  endtask

  task automatic test_invert_mode_change();
    int acc = 0, outs = 0;
    mstr_ready = 1'b1;
    set_slave(3, 1'b1, 2'b11, 8'h12, 32'h00_7F_80_FF);
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (slv_data_valid[3] && slv_rdy[3]) acc++;
      if (mstr_data_valid != '0) begin
        outs++;
        checks++;
        if (mstr_data !== 32'hFF_80_7F_00 || mstr_data_valid !== 4'b1000) begin
          failures++;
          $display("FAIL invert_beat: got tag=%b data=%h want tag=1000 data=ff807f00", mstr_data_valid, mstr_data);
        end
      end
      step();
      if (acc >= 1) set_slave(3, 1'b1, 2'b01, 8'h55, 32'h00_7F_80_FF);
      if (acc == 3) slv_data_valid[3] = 1'b0;
    end
    checks++; if (outs != 3) begin failures++; $display("FAIL invert_out_count: got=%0d want=3", outs); end
  endtask

  task automatic test_gap();
    int acc1 = 0, acc2 = 0;
    bit granted = 1'b0;
    ev_log.delete();
    blen_log.delete();
    mstr_ready = 1'b1;
    set_slave(1, 1'b1, 2'b00, 8'h00, $urandom);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (slv_rdy[1]) granted = 1'b1;
      if (slv_data_valid[1] && slv_rdy[1]) acc1++;
      if (slv_data_valid[2] && slv_rdy[2]) acc2++;
      step();
      slv_data[1*DW +: DW] = $urandom;
      if (granted && t < 3) begin
        set_slave(0, 1'b1, 2'b01, 8'($urandom), $urandom);
        set_slave(2, 1'b1, 2'b10, 8'($urandom), $urandom);
      end
      if (acc1 == 2) slv_data_valid[1] = 1'b0;
      if (acc2 == 1) slv_data_valid[2] = 1'b0;
    end
    drain(12);
    checks++;
    if (ev_log.size() < 4) begin
      failures++;
      $display("FAIL gap_events: got=%0d want>=4", ev_log.size());
    end else begin
      checks++;
      if (ev_log[0] != 1 || ev_log[1] != EV_CMPLT || ev_log[2] != 2 || ev_log[3] != EV_CMPLT) begin
        failures++;
        $display("FAIL gap_order: got=%0d,%0d,%0d,%0d want=1,%0d,2,%0d", ev_log[0], ev_log[1], ev_log[2], ev_log[3], EV_CMPLT, EV_CMPLT);
      end
      checks++;
      if (blen_log[0] != 2) begin failures++; $display("FAIL gap_burst_len: got=%0d want=2", blen_log[0]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    mstr_ready = 1'b0;
    set_slave(1, 1'b1, 2'b01, 8'($urandom), $urandom);
    @(negedge clk);
    while (mstr_data_valid == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mstr_data_valid == '0) begin failures++; $display("FAIL midrst_no_beat: got=%b want=nonzero", mstr_data_valid); end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ev_log.delete();
    mstr_ready = 1'b1;
    for (int i = 0; i < NS; i++) set_slave(i, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), $urandom);
    @(negedge clk);
    checks++; if (slv_rdy !== '0) begin failures++; $display("FAIL midrst_slv_rdy: got=%b want=0", slv_rdy); end
    checks++; if (mstr_data !== '0) begin failures++; $display("FAIL midrst_mstr_data: got=%h want=0", mstr_data); end
    checks++; if (mstr_data_valid !== '0) begin failures++; $display("FAIL midrst_mstr_valid: got=%b want=0", mstr_data_valid); end
    checks++; if (mstr_cmplt !== 1'b0) begin failures++; $display("FAIL midrst_cmplt: got=%b want=0", mstr_cmplt); end
    repeat (8) step();
    drain(12);
    checks++;
    if (ev_log.size() == 0 || ev_log[0] != 0) begin
      failures++;
      $display("FAIL midrst_first_grant: got=%0d want=0", (ev_log.size() == 0) ? -1 : ev_log[0]);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 3) == 0) slv_data_valid[i] = ~slv_data_valid[i];
        slv_mode[2*i +: 2]       = 2'($urandom_range(0, 3));
        slv_proc_val[i*CS +: CS] = 8'($urandom);
        slv_data[i*DW +: DW]     = $urandom;
      end
      mstr_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(20);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL random_leftover_beats: got=%0d want=0", exp_q.size()); end
    checks++; if (pending != 0) begin failures++; $display("FAIL random_missing_cmplt: got=%0d want=0", pending); end
  endtask

  initial begin
    slv_mode       = '0;
    slv_data_valid = '0;
    slv_proc_val   = '0;
    slv_data       = '0;
    mstr_ready     = 1'b0;
    test_reset();
    test_single_add();
    drain(4);
    test_round_robin();
    test_stall();
    test_invert_mode_change();
    drain(4);
    test_gap();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
